// File: rtl/hams_bram_stream_reader_if.sv
// Bundles the control, BRAM and stream signals of the BRAM stream reader.
// The master side is the reader; the slave side is the surrounding system.
`timescale 1ns/1ps
interface hams_bram_stream_reader_if #(
  parameter int DATA_DEPTH = 16,
  parameter int DATA_WIDTH = 8
);
  localparam int AW = $clog2(DATA_DEPTH);

  logic                  start;
  logic [AW-1:0]         base_addr;
  logic [AW:0]           len;
  logic                  busy;
  logic                  done;
  logic [AW-1:0]         bram_addr;
  logic                  bram_wr_en;
  logic [DATA_WIDTH-1:0] bram_rd_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;

  modport master (
    input  start, base_addr, len, bram_rd_data, m_ready,
    output busy, done, bram_addr, bram_wr_en, m_valid, m_data, m_last
  );

  modport slave (
    output start, base_addr, len, bram_rd_data, m_ready,
    input  busy, done, bram_addr, bram_wr_en, m_valid, m_data, m_last
  );
endinterface

// File: rtl/hams_bram_stream_reader.sv
// Reads a burst of words from a registered-output BRAM and streams them out
// through a valid/ready port, buffering returning data in a 2-entry FIFO.
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start; base_addr/len sampled here
// RUN   | issuing reads and streaming beats until the last is accepted
// DONE  | one-cycle completion pulse, then back to IDLE
`timescale 1ns/1ps
module hams_bram_stream_reader #(
  parameter int DATA_DEPTH = 16,
  parameter int DATA_WIDTH = 8
) (
  input logic clk,
  input logic rst_n,
  hams_bram_stream_reader_if.master bus
);
  localparam int AW = $clog2(DATA_DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         base_q;
  logic [AW-1:0]         addr_q;
  logic [AW-1:0]         rd_addr;
  logic [LW-1:0]         len_q;
  logic [LW-1:0]         issued_q;
  logic [LW-1:0]         popped_q;
  logic                  inflight_q;
  logic [DATA_WIDTH-1:0] fifo_mem [2];
  logic                  rd_ptr_q;
  logic                  wr_ptr_q;
  logic [1:0]            fifo_cnt_q;
  logic [2:0]            occ;
  logic                  valid;
  logic                  pop;
  logic                  issue;
  logic                  start_ok;
  logic                  last_beat;

  // Handshake and read-issue decisions. A read is only issued when the FIFO
  // is guaranteed to have room for its data one cycle later.
  always_comb begin
    start_ok  = (state_q == S_IDLE) && bus.start;
    valid     = (fifo_cnt_q != 2'd0);
    pop       = valid && bus.m_ready;
    occ       = {1'b0, fifo_cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    issue     = (state_q == S_RUN) && (issued_q < len_q) && (occ < 3'd2);
    rd_addr   = base_q + issued_q[AW-1:0];
    last_beat = pop && (popped_q == len_q - LW'(1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) state_d = (bus.len == '0) ? S_DONE : S_RUN;
      S_RUN:  if (last_beat) state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: status from the state, stream from the FIFO head, address held
  // between reads so the BRAM sees a stable value.
  always_comb begin
    bus.busy       = (state_q != S_IDLE);
    bus.done       = (state_q == S_DONE);
    bus.bram_wr_en = 1'b0;
    bus.bram_addr  = issue ? rd_addr : addr_q;
    bus.m_valid    = valid;
    bus.m_data     = fifo_mem[rd_ptr_q];
    bus.m_last     = valid && (popped_q == len_q - LW'(1));
  end

  // Burst bookkeeping, read tracking and the 2-entry FIFO.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      base_q      <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      issued_q    <= '0;
      popped_q    <= '0;
      inflight_q  <= 1'b0;
      rd_ptr_q    <= 1'b0;
      wr_ptr_q    <= 1'b0;
      fifo_cnt_q  <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      if (start_ok) begin
        base_q   <= bus.base_addr;
        len_q    <= bus.len;
        issued_q <= '0;
        popped_q <= '0;
      end
      if (issue) begin
        addr_q   <= rd_addr;
        issued_q <= issued_q + LW'(1);
      end
      // Read data lands one cycle after its address; only capture reads we
      // actually issued, so stale data after reset is dropped.
      inflight_q <= issue;
      if (inflight_q) begin
        fifo_mem[wr_ptr_q] <= bus.bram_rd_data;
        wr_ptr_q           <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        popped_q <= popped_q + LW'(1);
      end
      fifo_cnt_q <= fifo_cnt_q + {1'b0, inflight_q} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_hams_bram_stream_reader.sv
// Bench for the BRAM stream reader: a queue-based model of the expected beats,
// busy and done, checked every cycle, plus literal cycle-exact expectations.
`timescale 1ns/1ps
module tb_hams_bram_stream_reader;
  localparam int DEPTH = 16;
  localparam int WIDTH = 8;

  logic clk;
  logic rst_n;

  hams_bram_stream_reader_if #(.DATA_DEPTH(DEPTH), .DATA_WIDTH(WIDTH)) bus ();

  hams_bram_stream_reader #(.DATA_DEPTH(DEPTH), .DATA_WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] exp_q [$];
  int   n_vec;
  int   n_fail;
  int   n_beats;
  bit   mon_en;
  bit   busy_exp;
  bit   done_exp;
  bit   prev_stall;
  logic [WIDTH-1:0] prev_data;
  logic prev_last;
  bit   ready_rand;

  logic [WIDTH-1:0] tr_data  [0:15];
  logic             tr_valid [0:15];
  logic             tr_last  [0:15];
  logic             tr_done  [0:15];
  logic             tr_busy  [0:15];
  logic [3:0]       tr_addr  [0:15];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-output BRAM: data for the address of cycle t appears in t+1.
  initial forever begin
    @(posedge clk);
    bus.bram_rd_data <= mem[bus.bram_addr];
  end

  // Sink readiness: always ready, or random per cycle.
  initial forever begin
    @(posedge clk);
    #1;
    bus.m_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      bit last_pop;
      last_pop = 1'b0;
      chk("busy", 32'(bus.busy), 32'(busy_exp));
      chk("done", 32'(bus.done), 32'(done_exp));
      chk("wr_en", 32'(bus.bram_wr_en), 32'(0));
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.m_valid), 32'(1));
        chk("stall_data", 32'(bus.m_data), 32'(prev_data));
        chk("stall_last", 32'(bus.m_last), 32'(prev_last));
      end
      if (bus.m_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_valid", 32'(bus.m_valid), 32'(0));
        end else begin
          chk("data", 32'(bus.m_data), 32'(exp_q[0]));
          chk("last", 32'(bus.m_last), 32'(exp_q.size() == 1));
          if (bus.m_ready) begin
            void'(exp_q.pop_front());
            n_beats++;
            if (exp_q.size() == 0) last_pop = 1'b1;
          end
        end
      end
      prev_stall = bus.m_valid && !bus.m_ready;
      prev_data  = bus.m_data;
      prev_last  = bus.m_last;
      if (done_exp) busy_exp = 1'b0;
      done_exp = last_pop;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive start for one cycle; the model accepts it only if it believes the
  // block is idle in that cycle.
  task automatic start_burst(input int b, input int l);
    bit acc;
    bus.start     = 1'b1;
    bus.base_addr = 4'(b);
    bus.len       = 5'(l);
    acc = !busy_exp && rst_n;
    tick();
    bus.start     = 1'b0;
    bus.base_addr = 4'($urandom_range(0, 15));
    bus.len       = 5'($urandom_range(0, 16));
    if (acc) begin
      for (int i = 0; i < l; i++) exp_q.push_back(mem[4'((b + i) % DEPTH)]);
      busy_exp = 1'b1;
      if (l == 0) done_exp = 1'b1;
    end
  endtask

  task automatic wait_idle(input int max_cyc);
    int k;
    k = 0;
    while ((busy_exp || exp_q.size() != 0) && k < max_cyc) begin
      tick();
      k++;
    end
    if (k >= max_cyc) chk("idle_timeout", 32'(exp_q.size()), 32'(0));
    tick();
  endtask

  // Record n cycles of outputs, cycle 1 being the first after the start edge.
  task automatic trace(input int n);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      tr_data[k]  = bus.m_data;
      tr_valid[k] = bus.m_valid;
      tr_last[k]  = bus.m_last;
      tr_done[k]  = bus.done;
      tr_busy[k]  = bus.busy;
      tr_addr[k]  = bus.bram_addr;
    end
  endtask

  task automatic fill_linear();
    for (int i = 0; i < DEPTH; i++) mem[i] = 8'(i + 16'h10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0; n_fail = 0; n_beats = 0;
    mon_en = 1'b0; busy_exp = 1'b0; done_exp = 1'b0; prev_stall = 1'b0;
    prev_data = '0; prev_last = 1'b0; ready_rand = 1'b0;
    fill_linear();
    bus.start = 1'b0; bus.base_addr = '0; bus.len = '0; bus.m_ready = 1'b1;
    bus.bram_rd_data = '0;
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'(0));
    chk("rst_done", 32'(bus.done), 32'(0));
    chk("rst_valid", 32'(bus.m_valid), 32'(0));
    chk("rst_last", 32'(bus.m_last), 32'(0));
    chk("rst_addr", 32'(bus.bram_addr), 32'(0));
    chk("rst_data", 32'(bus.m_data), 32'(0));
    tick();
    rst_n = 1'b1;
    mon_en = 1'b1;
    tick();

    // base=2 len=4, sink always ready
    start_burst(2, 4);
    trace(8);
    chk("a_addr1", 32'(tr_addr[1]), 32'd2);
    chk("a_addr2", 32'(tr_addr[2]), 32'd3);
    chk("a_addr4", 32'(tr_addr[4]), 32'd5);
    chk("a_addr5_hold", 32'(tr_addr[5]), 32'd5);
    chk("a_valid2", 32'(tr_valid[2]), 32'd0);
    chk("a_valid3", 32'(tr_valid[3]), 32'd1);
    chk("a_data3", 32'(tr_data[3]), 32'h12);
    chk("a_data4", 32'(tr_data[4]), 32'h13);
    chk("a_data6", 32'(tr_data[6]), 32'h15);
    chk("a_last5", 32'(tr_last[5]), 32'd0);
    chk("a_last6", 32'(tr_last[6]), 32'd1);
    chk("a_done6", 32'(tr_done[6]), 32'd0);
    chk("a_done7", 32'(tr_done[7]), 32'd1);
    chk("a_busy7", 32'(tr_busy[7]), 32'd1);
    chk("a_busy8", 32'(tr_busy[8]), 32'd0);
    wait_idle(50);

    // address wrap: base=14 len=4
    start_burst(14, 4);
    trace(7);
    chk("b_addr1", 32'(tr_addr[1]), 32'd14);
    chk("b_addr2", 32'(tr_addr[2]), 32'd15);
    chk("b_addr3", 32'(tr_addr[3]), 32'd0);
    chk("b_addr4", 32'(tr_addr[4]), 32'd1);
    chk("b_data3", 32'(tr_data[3]), 32'h1E);
    chk("b_data4", 32'(tr_data[4]), 32'h1F);
    chk("b_data5", 32'(tr_data[5]), 32'h10);
    chk("b_data6", 32'(tr_data[6]), 32'h11);
    wait_idle(50);

    // empty burst
    start_burst(7, 0);
    trace(3);
    chk("c_done1", 32'(tr_done[1]), 32'd1);
    chk("c_busy2", 32'(tr_busy[2]), 32'd0);
    chk("c_done2", 32'(tr_done[2]), 32'd0);
    for (int k = 1; k <= 3; k++) chk("c_valid", 32'(tr_valid[k]), 32'd0);
    wait_idle(50);

    // start during a burst is ignored
    n_beats = 0;
    start_burst(3, 6);
    tick();
    tick();
    start_burst(9, 2);
    wait_idle(80);
    chk("d_beats", 32'(n_beats), 32'd6);

    // reset after the second beat of a len=8 burst
    n_beats = 0;
    start_burst(0, 8);
    for (int k = 0; k < 40 && n_beats < 2; k++) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    busy_exp = 1'b0;
    done_exp = 1'b0;
    prev_stall = 1'b0;
    @(negedge clk);
    chk("e_valid", 32'(bus.m_valid), 32'd0);
    chk("e_busy", 32'(bus.busy), 32'd0);
    chk("e_last", 32'(bus.m_last), 32'd0);
    chk("e_addr", 32'(bus.bram_addr), 32'd0);
    chk("e_data", 32'(bus.m_data), 32'd0);
    tick();
    tick();
    n_beats = 0;
    start_burst(5, 8);
    wait_idle(80);
    chk("e_beats", 32'(n_beats), 32'd8);

    // randomized bursts with random back-pressure
    ready_rand = 1'b1;
    for (int n = 0; n < 24; n++) begin
      int b, l;
      if (n == 3) fill_linear();
      else for (int i = 0; i < DEPTH; i++) mem[i] = 8'($urandom);
      b = $urandom_range(0, DEPTH - 1);
      l = $urandom_range(0, DEPTH);
      if (n == 3) l = DEPTH;
      if (n == 5 || n == 9) l = 5;
      n_beats = 0;
      start_burst(b, l);
      if ($urandom_range(0, 1) == 1) begin
        tick();
        start_burst($urandom_range(0, DEPTH - 1), $urandom_range(1, DEPTH));
      end
      wait_idle(400);
    end
    ready_rand = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
